// File: rtl/iram_param_if.sv
// Fetch/program bus for iram_param.
// Fetch side : ADDR (byte address) -> Q (instruction word), ALIGN_ERR.
// Program side: PWE/PADDR/PDATA write request, PREADY acceptance flag.
// Control     : CLR requests a full re-clear; BUSY and WCOUNT report status.
// The parameters must match the ones given to the iram_param instance.
interface iram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Q;
    logic              ALIGN_ERR;
    logic              CLR;
    logic              PWE;
    logic [ADDR_W-2:0] PADDR;
    logic [DATA_W-1:0] PDATA;
    logic              PREADY;
    logic              BUSY;
    logic [7:0]        WCOUNT;

    // Master drives fetch address, program writes and clear requests.
    modport master (
        output ADDR, CLR, PWE, PADDR, PDATA,
        input  Q, ALIGN_ERR, PREADY, BUSY, WCOUNT
    );

    // Slave is the memory itself.
    modport slave (
        input  ADDR, CLR, PWE, PADDR, PDATA,
        output Q, ALIGN_ERR, PREADY, BUSY, WCOUNT
    );
endinterface

// File: rtl/iram_param.sv
// Parameterised instruction RAM with a self-clearing sequence.
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RESET - asynchronous active-low reset; restarts the full clear on release
//   bus   - iram_param_if slave: combinational fetch (ADDR -> Q, ALIGN_ERR),
//           program write (PWE/PADDR/PDATA, PREADY), CLR request, BUSY, WCOUNT
// After reset or a CLR request the memory spends DEPTH cycles writing FILL
// into every word (BUSY=1, Q forced to 0), then enters RUN where fetches are
// combinational and program writes are accepted.
module iram_param #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 8,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic         CLK,
    input  logic         RESET,
    iram_param_if.slave  bus
);
    localparam int                PTR_W = ADDR_W - 1;
    localparam int                DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [7:0]        wcount_q, wcount_d;
    logic              clr_we;
    logic              prog_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state logic. Leaving CLEAR keeps clr_ptr at LAST; it is only
    // rewound when a new clear starts (CLR in RUN, or reset).
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wcount_d  = wcount_q;
        clr_we    = 1'b0;
        prog_we   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // CLR and PWE are deliberately ignored here.
                clr_we = 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.CLR) begin
                    // Clear wins over a simultaneous program write.
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    wcount_d  = '0;
                end else if (bus.PWE) begin
                    prog_we = 1'b1;
                    if (wcount_q != 8'hFF) begin
                        wcount_d = wcount_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wcount_q  <= wcount_d;
        end
    end

    // Memory array has no reset. Writes are also gated by RESET so nothing
    // is written while reset is held; clearing starts on the first edge
    // after release.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (clr_we) begin
                mem[clr_ptr_q] <= FILL;
            end else if (prog_we) begin
                mem[bus.PADDR] <= bus.PDATA;
            end
        end
    end

    // Combinational fetch: a write to the fetched word shows up only after
    // the edge. The low address bit selects nothing, it only flags misalignment.
    assign bus.Q         = (state_q == ST_RUN) ? mem[bus.ADDR[ADDR_W-1:1]] : '0;
    assign bus.ALIGN_ERR = bus.ADDR[0];
    assign bus.BUSY      = (state_q == ST_CLEAR);
    assign bus.PREADY    = (state_q == ST_RUN) && !bus.CLR;
    assign bus.WCOUNT    = wcount_q;

endmodule
